dsm_bitstream_decimator: RTL and testbench
==========================================

Name: dsm_bitstream_decimator

Overview:
- Receive-side counterpart of the delta-sigma DAC modulator: turns a 1-bit delta-sigma bitstream back into signed PCM samples.
- Structure: second-order CIC (sinc2) decimator with ratio R = 2^OSR_LOG2, followed by scaling, saturation and a one-entry valid/ready output holding register.
- Scaling maps bit density back to the modulator input code, with FEEDBACK_MAG = 2^(DATA_WIDTH-1).
- Used for loopback checking of the DAC path and as the decoder for external 1-bit modulator sources.

Parameters:
- DATA_WIDTH, 4, width of the signed PCM output; matches the modulator input width.
- OSR_LOG2, 4, log2 of the decimation ratio R. Constraint: 2*OSR_LOG2 >= DATA_WIDTH-1.
- INT_WIDTH, 2*OSR_LOG2+2, width of the integrator, delay and comb registers. Values below the default are clamped up to the default.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_en  input  1  bitstream strobe; i_bitstream is consumed only on cycles with i_en=1
- i_bitstream  input  1  delta-sigma bit; 1 maps to +1, 0 maps to -1
- o_data  output  DATA_WIDTH  signed decimated sample
- o_valid  output  1  o_data holds an unconsumed sample
- i_ready  input  1  consumer accepts o_data on a cycle where o_valid=1 and i_ready=1
- o_overrun  output  1  sticky flag: an unconsumed sample was overwritten

Behaviour:
- Reset (asynchronous assert, synchronous release with the clock): all integrators, delays, combs and the phase counter = 0; warm-up count = 0; o_data = 0; o_valid = 0; o_overrun = 0.
- Integrator stage, on each i_en cycle, with x = +1/-1 sign-extended to INT_WIDTH:
  - int1_n = int1 + x
  - int2_n = int2 + int1_n
  - int1 <= int1_n, int2 <= int2_n
  - Arithmetic is modular (wrap-around is intentional and cancelled by the combs).
- Phase counter counts 0..R-1 on i_en cycles only. Decimation strobe = i_en and phase == R-1; the phase counter then wraps to 0.
- On the strobe, using the same-cycle int2_n (so the window includes the current bit):
  - c1 = int2_n - d1; d1 <= int2_n
  - c2 = c1 - d2; d2 <= c1
  - c2 range is [-R^2, +R^2].
- Scaling: s = c2 >>> (2*OSR_LOG2 - (DATA_WIDTH-1)), arithmetic shift, truncation toward negative infinity. Then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; +R^2 maps to the maximum code.
- Warm-up state machine, states WARMUP0 -> WARMUP1 -> RUN:
  - Each strobe advances one state.
  - Strobes in WARMUP0 and WARMUP1 update the combs but are not presented on the output.
  - In RUN, each strobe loads o_data and sets o_valid.
  - The first o_valid rises on the clock edge that consumes the 3R-th enabled bit after reset.
- Latency: o_valid/o_data are visible in the cycle after the strobe cycle.
- Output handshake:
  - o_valid=1 and i_ready=1 with no strobe: o_valid <= 0 next cycle; o_data holds its value.
  - o_data is stable while o_valid=1, except on overwrite.
  - Strobe while o_valid=1 and i_ready=0: o_data is overwritten, o_valid stays 1, o_overrun <= 1.
  - Strobe in the same cycle as an accept: new sample loaded, o_valid stays 1, no overrun.
  - o_overrun clears only on reset.
- i_en=0: no integrator, phase or comb state changes. The handshake still operates.
- Reset mid-window or mid-handshake: all state is discarded immediately and the warm-up restarts.

Optional Feature:
- Macro: DSM_DEC_ROUND_EN.
- Defined: before the shift, add 2^(shift-1) to c2 (round half up), then saturate. Saturation also covers the rounding carry.
- Undefined: plain truncating arithmetic shift, as described above.
- Warm-up, handshake and latency are identical in both builds.

Test Plan (defaults DATA_WIDTH=4, R=16, shift=5):
- Reset, then constant bitstream 1 with i_en=1 and i_ready=1 -> first o_valid after 48 bits; o_data = 7 (saturated from +8) every 16 bits.
- Constant bitstream 0 -> o_data = -8 after warm-up; o_overrun stays 0.
- Repeating 1,0 pattern -> o_data = 0 in every RUN output. Repeating 1,1,1,0 pattern -> o_data = 4 (c2 = 128).
- Loopback from the DAC modulator (DATA_WIDTH=4) with input -3 held, i_en=1, 200 outputs -> mean of o_data = -3 +/- 1.
- i_ready=0 across two strobes -> o_valid stays 1, o_data = the newest sample, o_overrun = 1. Accept in the same cycle as a strobe -> no overrun. Assert i_rst mid-window -> all outputs 0 immediately, 48 bits needed again for the first o_valid.
- i_en toggled 1-in-3 cycles with the 1,1,1,0 pattern -> same o_data = 4 values, each strobe spaced 48 clocks apart.

Source files
------------

// File: rtl/dsm_bitstream_decimator.sv
// dsm_bitstream_decimator
// Decodes a 1-bit delta-sigma bitstream into signed PCM samples using a
// second-order CIC (sinc2) decimator with ratio R = 2^OSR_LOG2. The CIC output
// is scaled and saturated, then held in a one-entry valid/ready register.
// Optional build macro: DSM_DEC_ROUND_EN. When defined, it adds round-half-up
// before the scaling shift. When undefined, the shift truncates toward
// negative infinity.
module dsm_bitstream_decimator #(
   parameter int DATA_WIDTH = 4,
   parameter int OSR_LOG2   = 4,
   parameter int INT_WIDTH  = 2*OSR_LOG2+2
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_en,
   input  logic                         i_bitstream,
   output logic signed [DATA_WIDTH-1:0] o_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_overrun
);

   // Integrators must hold +/-R^2 plus a sign bit, so narrower requests are widened
   localparam int IW_MIN = 2*OSR_LOG2 + 2;
   localparam int IW     = (INT_WIDTH < IW_MIN) ? IW_MIN : INT_WIDTH;
   localparam int SHIFT  = 2*OSR_LOG2 - (DATA_WIDTH-1);
   localparam int MAX_I  = (2**(DATA_WIDTH-1)) - 1;
   localparam int MIN_I  = -(2**(DATA_WIDTH-1));

   localparam logic signed [IW-1:0] MAX_CODE = IW'(MAX_I);
   localparam logic signed [IW-1:0] MIN_CODE = IW'(MIN_I);
   localparam logic signed [IW-1:0] X_POS    = IW'(1);
   localparam logic signed [IW-1:0] X_NEG    = IW'(-1);
   localparam logic [OSR_LOG2-1:0]  PHASE_ONE = OSR_LOG2'(1);
`ifdef DSM_DEC_ROUND_EN
   localparam int ROUND_I = (SHIFT > 0) ? (2**(SHIFT-1)) : 0;
   localparam logic signed [IW-1:0] ROUND_BIAS = IW'(ROUND_I);
`endif

   typedef enum logic [1:0] {
      WARMUP0,
      WARMUP1,
      RUN
   } state_t;

   state_t state;

   logic signed [IW-1:0] int1;
   logic signed [IW-1:0] int2;
   logic signed [IW-1:0] d1;
   logic signed [IW-1:0] d2;
   logic signed [IW-1:0] x;
   logic signed [IW-1:0] int1_n;
   logic signed [IW-1:0] int2_n;
   logic signed [IW-1:0] c1;
   logic signed [IW-1:0] c2;
   logic signed [IW-1:0] biased;
   logic signed [IW-1:0] scaled;
   logic signed [DATA_WIDTH-1:0] sat;
   logic [OSR_LOG2-1:0]  phase;
   logic                 strobe;

   // Integrator sums, comb differences, scaling and saturation for the current bit
   always_comb begin
      x      = i_bitstream ? X_POS : X_NEG;
      int1_n = int1 + x;
      int2_n = int2 + int1_n;
      c1     = int2_n - d1;
      c2     = c1 - d2;
`ifdef DSM_DEC_ROUND_EN
      biased = c2 + ROUND_BIAS;
`else
      biased = c2;
`endif
      scaled = biased >>> SHIFT;
      if (scaled > MAX_CODE) begin
         sat = MAX_CODE[DATA_WIDTH-1:0];
      end else if (scaled < MIN_CODE) begin
         sat = MIN_CODE[DATA_WIDTH-1:0];
      end else begin
         sat = scaled[DATA_WIDTH-1:0];
      end
      strobe = i_en && (&phase);
   end

   // Integrators and phase counter advance on enabled bits; combs update on the strobe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         int1  <= '0;
         int2  <= '0;
         d1    <= '0;
         d2    <= '0;
         phase <= '0;
      end else if (i_en) begin
         int1  <= int1_n;
         int2  <= int2_n;
         phase <= phase + PHASE_ONE;
         if (strobe) begin
            d1 <= int2_n;
            d2 <= c1;
         end
      end
   end

   // Warm-up sequencing and the valid/ready output register with sticky overrun
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= WARMUP0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (strobe) begin
            case (state)
               WARMUP0: state <= WARMUP1;
               WARMUP1: state <= RUN;
               default: state <= RUN;
            endcase
         end
         if (strobe && (state == RUN)) begin
            o_data  <= sat;
            o_valid <= 1'b1;
            if (o_valid && !i_ready) begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsm_bitstream_decimator.sv
// tb_dsm_bitstream_decimator
// Directed self-checking bench for dsm_bitstream_decimator at default parameters
// (DATA_WIDTH=4, R=16, shift=5). Honours DSM_DEC_ROUND_EN where results differ.
module tb_dsm_bitstream_decimator;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_en;
   logic              i_bitstream;
   logic              i_ready;
   logic signed [3:0] o_data;
   logic              o_valid;
   logic              o_overrun;

   int checks   = 0;
   int failures = 0;

   dsm_bitstream_decimator #(
      .DATA_WIDTH(4),
      .OSR_LOG2(4)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en(i_en),
      .i_bitstream(i_bitstream),
      .o_data(o_data),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_overrun(o_overrun)
   );

   // Free-running 10-unit clock
   always #5 i_clk = ~i_clk;

   task automatic step(input logic en, input logic b);
      i_en        = en;
      i_bitstream = b;
      @(posedge i_clk);
      #1;
   endtask

   task automatic feed_const(input int n, input logic b);
      for (int k = 0; k < n; k++) step(1'b1, b);
   endtask

   task automatic feed_pat(input int n, input logic [3:0] pat, input int plen);
      for (int k = 0; k < n; k++) step(1'b1, pat[k % plen]);
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_en        = 1'b0;
      i_bitstream = 1'b0;
      i_ready     = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst       = 1'b1;
      i_en        = 1'b0;
      i_bitstream = 1'b0;
      i_ready     = 1'b1;
      #2;
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
      checks++;
      if (o_data !== 4'sd0) begin failures++; $display("[TB] FAIL reset_data got=%0d exp=0", o_data); end
      checks++;
      if (o_overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", o_overrun); end
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic test_const_one();
      do_reset();
      feed_const(47, 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL one_valid_47 got=%b exp=0", o_valid); end
      step(1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL one_valid_48 got=%b exp=1", o_valid); end
      checks++;
      if (o_data !== 4'sd7) begin failures++; $display("[TB] FAIL one_data_48 got=%0d exp=7", o_data); end
      feed_const(15, 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL one_accepted got=%b exp=0", o_valid); end
      step(1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd7) begin
         failures++; $display("[TB] FAIL one_data_64 got=%b/%0d exp=1/7", o_valid, o_data);
      end
   endtask

   task automatic test_const_zero();
      logic signed [3:0] expv;
      expv = -4'sd8;
      do_reset();
      feed_const(48, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== expv) begin
         failures++; $display("[TB] FAIL zero_first got=%b/%0d exp=1/-8", o_valid, o_data);
      end
      feed_const(48, 1'b0);
      checks++;
      if (o_data !== expv) begin failures++; $display("[TB] FAIL zero_later got=%0d exp=-8", o_data); end
      checks++;
      if (o_overrun !== 1'b0) begin failures++; $display("[TB] FAIL zero_overrun got=%b exp=0", o_overrun); end
   endtask

   task automatic test_alternating();
      do_reset();
      feed_pat(48, 4'b0101, 2);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd0) begin
         failures++; $display("[TB] FAIL alt_first got=%b/%0d exp=1/0", o_valid, o_data);
      end
      feed_pat(16, 4'b0101, 2);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd0) begin
         failures++; $display("[TB] FAIL alt_second got=%b/%0d exp=1/0", o_valid, o_data);
      end
   endtask

   task automatic test_pattern_1110();
      do_reset();
      feed_pat(48, 4'b0111, 4);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd4) begin
         failures++; $display("[TB] FAIL p1110_first got=%b/%0d exp=1/4", o_valid, o_data);
      end
      feed_pat(32, 4'b0111, 4);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd4) begin
         failures++; $display("[TB] FAIL p1110_later got=%b/%0d exp=1/4", o_valid, o_data);
      end
   endtask

   task automatic test_loopback();
      int e;
      int v;
      int got;
      int sum;
      int cyc;
      logic b;
      e   = 0;
      got = 0;
      sum = 0;
      cyc = 0;
      do_reset();
      while (got < 200 && cyc < 5000) begin
         v = -3 + e;
         b = (v >= 0);
         e = v - (b ? 8 : -8);
         step(1'b1, b);
         cyc++;
         if (o_valid === 1'b1) begin
            sum += int'(o_data);
            got++;
         end
      end
      checks++;
      if (got != 200) begin failures++; $display("[TB] FAIL loop_count got=%0d exp=200", got); end
      checks++;
      if (sum < -800 || sum > -400) begin
         failures++; $display("[TB] FAIL loop_mean sum=%0d exp range -800..-400", sum);
      end
   endtask

   task automatic test_overrun();
      logic signed [3:0] expv;
      expv = -4'sd8;
      do_reset();
      feed_const(49, 1'b1);
      i_ready = 1'b0;
      feed_const(15, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL ovr_first got=%b/%b exp=1/0", o_valid, o_overrun);
      end
      feed_const(16, 1'b0);
      checks++;
      if (o_overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_flag got=%b exp=1", o_overrun); end
      feed_const(16, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== expv) begin
         failures++; $display("[TB] FAIL ovr_newest got=%b/%0d exp=1/-8", o_valid, o_data);
      end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== expv) begin
         failures++; $display("[TB] FAIL ovr_hold got=%b/%0d exp=1/-8", o_valid, o_data);
      end
      i_ready = 1'b1;
      step(1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_data !== expv || o_overrun !== 1'b1) begin
         failures++; $display("[TB] FAIL ovr_accept got=%b/%0d/%b exp=0/-8/1", o_valid, o_data, o_overrun);
      end
   endtask

   task automatic test_accept_on_strobe();
      logic signed [3:0] expv;
`ifdef DSM_DEC_ROUND_EN
      expv = 4'sd0;
`else
      expv = -4'sd1;
`endif
      do_reset();
      feed_const(48, 1'b1);
      i_ready = 1'b0;
      feed_const(15, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd7) begin
         failures++; $display("[TB] FAIL aos_held got=%b/%0d exp=1/7", o_valid, o_data);
      end
      i_ready = 1'b1;
      step(1'b1, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== expv || o_overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL aos_load got=%b/%0d/%b exp=1/%0d/0", o_valid, o_data, o_overrun, expv);
      end
   endtask

   task automatic test_reset_mid_window();
      do_reset();
      feed_const(48, 1'b1);
      i_ready = 1'b0;
      feed_const(24, 1'b1);
      checks++;
      if (o_overrun !== 1'b1 || o_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL rmw_pre got=%b/%b exp=1/1", o_valid, o_overrun);
      end
      i_rst = 1'b1;
      #2;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 4'sd0 || o_overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL rmw_clear got=%b/%0d/%b exp=0/0/0", o_valid, o_data, o_overrun);
      end
      @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      i_ready = 1'b1;
      feed_const(47, 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmw_47 got=%b exp=0", o_valid); end
      step(1'b1, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 4'sd7) begin
         failures++; $display("[TB] FAIL rmw_48 got=%b/%0d exp=1/7", o_valid, o_data);
      end
   endtask

   task automatic test_enable_gaps();
      logic [3:0] pat;
      int bitk;
      int first;
      int second;
      int bits_at_first;
      logic prev;
      pat    = 4'b0111;
      bitk   = 0;
      first  = -1;
      second = -1;
      bits_at_first = -1;
      prev   = 1'b0;
      do_reset();
      for (int c = 0; c < 400 && second < 0; c++) begin
         if (c % 3 == 0) begin
            step(1'b1, pat[bitk % 4]);
            bitk++;
         end else begin
            step(1'b0, 1'b0);
         end
         if (o_valid === 1'b1 && prev === 1'b0) begin
            if (first < 0) begin
               first = c;
               bits_at_first = bitk;
            end else begin
               second = c;
            end
            checks++;
            if (o_data !== 4'sd4) begin failures++; $display("[TB] FAIL gap_data got=%0d exp=4", o_data); end
         end
         prev = o_valid;
      end
      checks++;
      if (bits_at_first != 48) begin
         failures++; $display("[TB] FAIL gap_first_bits got=%0d exp=48", bits_at_first);
      end
      checks++;
      if (second < 0 || (second - first) != 48) begin
         failures++; $display("[TB] FAIL gap_spacing got=%0d exp=48", second - first);
      end
   endtask

   // Runs every scenario in order and prints the summary
   initial begin
      test_reset();
      test_const_one();
      test_const_zero();
      test_alternating();
      test_pattern_1110();
      test_loopback();
      test_overrun();
      test_accept_on_strobe();
      test_reset_mid_window();
      test_enable_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
